fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised, decoupled instruction-fetch front end for the pipelined CPU. It owns the PC, issues instruction requests to the instruction cache through the datapath–cache interface signals, and queues returned instructions with their PCs in a DEPTH-entry buffer for decode. The buffer is flushed on redirect and fetch stops on halt, which the single-cycle datapath's bare PC register and PC-source muxing cannot do.

## Interface
- PC_INIT, 0, fetch PC after reset (word aligned)
- DEPTH, 4, instruction buffer entries; power of two, ≥2
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  icache hit; imemload valid this cycle
- imemload  in  32  instruction from icache
- imemREN  out  1  instruction read request
- imemaddr  out  32  fetch address, registered
- redirect  in  1  branch/jump resolved; flush and refetch
- redirect_pc  in  32  new fetch target
- halt  in  1  halt decoded; stop fetching (sticky)
- inst_ready  in  1  decode accepts head entry
- inst_valid  out  1  head entry valid
- inst  out  32  head instruction
- inst_pc  out  32  PC of head instruction
- inst_npc  out  32  inst_pc + 4
- count  out  $clog2(DEPTH+1)  occupied entries
- halted  out  1  fetch stopped by halt

## Operation
- States: FETCH, STALL, HALTED.
- FETCH: imemREN=1, imemaddr=fetch_pc. ihit → push {imemload, fetch_pc}; fetch_pc += 4 (mod 2^32; 0xFFFFFFFC wraps to 0). Entering full → STALL.
- STALL: imemREN=0. A pop (count<DEPTH next) → FETCH.
- HALTED: imemREN=0 permanently until reset. The buffer still drains to decode; halted=1.
- halt in FETCH/STALL → HALTED next cycle. An ihit in the same cycle is still pushed.
- Pop: inst_valid && inst_ready.
- redirect (any state except HALTED):
  - count→0 and fetch_pc←{redirect_pc[31:2],2'b00}.
  - Any simultaneous ihit push and any pop are discarded.
  - Next state is FETCH.
- redirect in HALTED: ignored.
- Priority: reset > redirect > halt > push/pop.
- Push and pop in the same cycle: count unchanged. A push never occurs when full, because imemREN is derived from registered count/state.
- Mid-access redirect: imemaddr changes the next cycle. The icache treats the new address as a new request. A pending hit on the old address is never captured.

## Timing
- Reset values:
  - imemREN=0 while nRST low, 1 on the first edge after release.
  - imemaddr=PC_INIT.
  - inst_valid=0; inst, inst_pc=0; inst_npc=4.
  - count=0, halted=0, state FETCH.
- Fetch throughput is one instruction per cycle while ihit stays high and the buffer is not full.
- ihit → inst_valid latency: 1 cycle (see Configuration).
- redirect at cycle t:
  - t+1: imemaddr=redirect target and inst_valid=0.
  - First new instruction is valid at t+2 at the earliest, given ihit at t+1.
- Full → STALL: imemREN drops the cycle after the buffer fills.

## Configuration
- FETCH_BYPASS_EN defined:
  - Condition: count==0, ihit, imemREN=1, inst_ready=1 and no redirect.
  - imemload and fetch_pc appear combinationally on inst/inst_pc with inst_valid=1 in the same cycle. The instruction is consumed and not written into the buffer.
  - Latency is 0.
- Undefined: every instruction passes through the buffer; latency is 1 cycle.

## Structure
- cpu_types_pkg: add fetch_state_t (FETCH, STALL, HALTED) and fetch_entry_t struct {word_t inst; word_t pc}. Use the existing word_t.
- Sub-module fetch_fifo:
  - Parametrised by DEPTH; circular buffer of fetch_entry_t.
  - Push, pop, flush, count; flush has priority.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- PC+4 reuses the existing adder module.

## Test plan
- Reset release, PC_INIT=0, ihit=1, inst_ready=0 → imemaddr 0,4,8,12; count reaches 4; imemREN=0 from the next cycle; head inst_pc=0.
- Full buffer, pulse inst_ready one cycle → one pop (inst_pc=0); STALL→FETCH; next push has pc=16.
- ihit and inst_ready continuous at count=1 → count stays 1 and inst_pc increments by 4 each cycle.
- redirect_pc=0x00000123 with ihit and a pop in the same cycle → count=0, inst_valid=0 next cycle, imemaddr=0x00000120, push discarded.
- halt with ihit in the same cycle → instruction pushed, halted=1 next cycle, imemREN=0 forever; buffer drains; a later redirect is ignored.
- redirect_pc=0xFFFFFFFC, two hits → entries with pc 0xFFFFFFFC and 0x00000000. With FETCH_BYPASS_EN and an empty buffer, ihit+inst_ready gives inst_valid in the same cycle and count stays 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types, extended with the fetch front-end state and buffer entry.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        STALL  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t inst;
        word_t pc;
    } fetch_entry_t;

    function automatic word_t word_align(input word_t addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: icache request/response, decode handshake, redirect/halt control.
interface fetch_unit_if #(
    parameter int DEPTH = 4
);
    import cpu_types_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic          ihit;
    word_t         imemload;
    logic          imemREN;
    word_t         imemaddr;
    logic          redirect;
    word_t         redirect_pc;
    logic          halt;
    // Head entry moves to decode on a cycle where inst_valid && inst_ready;
    // inst_valid never depends on inst_ready except for the same-cycle bypass path.
    logic          inst_ready;
    logic          inst_valid;
    word_t         inst;
    word_t         inst_pc;
    word_t         inst_npc;
    logic [CW-1:0] count;
    logic          halted;
    fetch_state_t  state;

    modport master (
        input  ihit, imemload, redirect, redirect_pc, halt, inst_ready,
        output imemREN, imemaddr, inst_valid, inst, inst_pc, inst_npc,
               count, halted, state
    );

    modport slave (
        output ihit, imemload, redirect, redirect_pc, halt, inst_ready,
        input  imemREN, imemaddr, inst_valid, inst, inst_pc, inst_npc,
               count, halted, state
    );

endinterface

// File: rtl/adder.sv
// Generic W-bit adder, wraps modulo 2^W.
module adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/fetch_fifo.sv
// Circular instruction buffer of fetch entries; flush overrides push and pop.
module fetch_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_entry_t  wdata_i,
    output fetch_entry_t  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign do_push = push_i && (count_q != FULL_COUNT) && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer increments wrap on their own.
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push) mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: owns the PC, requests from icache, buffers for decode.
// Optional same-cycle icache-to-decode bypass when FETCH_BYPASS_EN is defined.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = '0,
    parameter int    DEPTH   = 4
) (
    input logic          CLK,
    input logic          nRST,
    fetch_unit_if.master bus
);

    localparam int            CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_state_t  state_q, state_d;
    word_t         fetch_pc_q, fetch_pc_d;
    logic          ren_q;
    word_t         pc_plus4, head_pc, head_npc;
    logic          redirect_ok, hit_taken, bypass, push, pop, fifo_empty;
    logic [CW-1:0] fifo_count, count_next;
    fetch_entry_t  push_entry, head;

    adder #(.W(32)) u_pc_inc  (.a_i(fetch_pc_q), .b_i(WORD_BYTES), .sum_o(pc_plus4));
    adder #(.W(32)) u_npc_inc (.a_i(head_pc),    .b_i(WORD_BYTES), .sum_o(head_npc));

    assign redirect_ok = bus.redirect && (state_q != HALTED);
    // ren_q is only high in FETCH, so a taken hit cannot coincide with HALTED.
    assign hit_taken   = ren_q && bus.ihit && !redirect_ok;

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty && bus.ihit && ren_q && bus.inst_ready && !bus.redirect;
`else
    assign bypass = 1'b0;
`endif

    assign push       = hit_taken && !bypass;
    assign pop        = !fifo_empty && bus.inst_ready && !redirect_ok;
    assign push_entry = '{inst: bus.imemload, pc: fetch_pc_q};
    assign count_next = redirect_ok ? '0 : (fifo_count + CW'(push) - CW'(pop));

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (CLK),
        .rst_n   (nRST),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_ok),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_ok) begin
            state_d    = FETCH;
            fetch_pc_d = word_align(bus.redirect_pc);
        end else begin
            if (hit_taken) fetch_pc_d = pc_plus4;
            unique case (state_q)
                FETCH, STALL: begin
                    if (bus.halt)                       state_d = HALTED;
                    else if (count_next == FULL_COUNT)  state_d = STALL;
                    else                                state_d = FETCH;
                end
                HALTED:  state_d = HALTED;
                default: state_d = FETCH;
            endcase
        end
    end

    // imemREN is registered so it stays low through reset and rises on the first edge after.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= FETCH;
            fetch_pc_q <= PC_INIT;
            ren_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ren_q      <= (state_d == FETCH);
        end
    end

    assign head_pc        = bypass ? fetch_pc_q : head.pc;
    assign bus.imemREN    = ren_q;
    assign bus.imemaddr   = fetch_pc_q;
    assign bus.inst_valid = bypass || !fifo_empty;
    assign bus.inst       = bypass ? bus.imemload : head.inst;
    assign bus.inst_pc    = head_pc;
    assign bus.inst_npc   = head_npc;
    assign bus.count      = fifo_count;
    assign bus.halted     = (state_q == HALTED);
    assign bus.state      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue model.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    localparam int    DEPTH   = 4;
    localparam word_t PC_INIT = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.DEPTH(DEPTH)) bus ();

    fetch_unit #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    fetch_entry_t model_q[$];
    word_t        m_pc;
    bit           m_halted;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs against the model, then advance the model.
    task automatic step(input logic ihit, input word_t load, input logic redir,
                        input word_t rpc, input logic halt, input logic ready);
        bit           exp_ren, byp, exp_valid;
        fetch_entry_t head;
        @(posedge clk);
        #1;
        bus.ihit        = ihit;
        bus.imemload    = load;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.halt        = halt;
        bus.inst_ready  = ready;
        @(negedge clk);
        exp_ren = !m_halted && (model_q.size() < DEPTH);
        byp     = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = (model_q.size() == 0) && ihit && exp_ren && ready && !redir;
`endif
        exp_valid = byp || (model_q.size() > 0);
        check("imemREN",    32'(bus.imemREN),    32'(exp_ren));
        check("imemaddr",   bus.imemaddr,        m_pc);
        check("inst_valid", 32'(bus.inst_valid), 32'(exp_valid));
        check("count",      32'(bus.count),      32'(model_q.size()));
        check("halted",     32'(bus.halted),     32'(m_halted));
        if (exp_valid) begin
            head = byp ? fetch_entry_t'{inst: load, pc: m_pc} : model_q[0];
            check("inst",     bus.inst,     head.inst);
            check("inst_pc",  bus.inst_pc,  head.pc);
            check("inst_npc", bus.inst_npc, head.pc + 32'd4);
        end
        if (redir && !m_halted) begin
            model_q.delete();
            m_pc = rpc & ~32'h3;
        end else begin
            if (exp_valid && ready && !byp) void'(model_q.pop_front());
            if (exp_ren && ihit) begin
                if (!byp) model_q.push_back(fetch_entry_t'{inst: load, pc: m_pc});
                m_pc = m_pc + 32'd4;
            end
            if (halt) m_halted = 1'b1;
        end
    endtask

    task automatic idle_drain();
        for (int i = 0; i < 2 * DEPTH && model_q.size() > 0; i++)
            step(1'b0, $urandom, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.ihit        = 1'b0;
        bus.imemload    = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        bus.inst_ready  = 1'b0;
        m_pc     = PC_INIT;
        m_halted = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_imemREN",    32'(bus.imemREN),    32'd0);
        check("rst_imemaddr",   bus.imemaddr,        PC_INIT);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst",       bus.inst,            32'd0);
        check("rst_inst_pc",    bus.inst_pc,         32'd0);
        check("rst_inst_npc",   bus.inst_npc,        32'd4);
        check("rst_count",      32'(bus.count),      32'd0);
        check("rst_halted",     32'(bus.halted),     32'd0);
        rst_n = 1'b1;

        // Fill the buffer with decode stalled.
        repeat (DEPTH + 2) step(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
        // Single pop from full, then refill.
        step(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (3) step(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);

        // Steady state at one entry with fetch and decode both streaming.
        for (int i = 0; i < 2 * DEPTH && model_q.size() > 1; i++)
            step(1'b0, $urandom, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (6) step(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 1'b1);

        // Redirect colliding with a hit and a pop; unaligned target.
        step(1'b1, $urandom, 1'b1, 32'h0000_0123, 1'b0, 1'b1);
        step(1'b0, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
        idle_drain();

        // PC wrap at the top of the address space.
        step(1'b0, $urandom, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        repeat (2) step(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
        idle_drain();
        // Empty buffer with hit and ready: exercises the bypass when enabled.
        repeat (3) step(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 1'b1);
        idle_drain();

        repeat (1500) begin
            step(1'($urandom_range(0, 3) != 0), $urandom,
                 1'($urandom_range(0, 15) == 0), $urandom, 1'b0,
                 1'($urandom_range(0, 1)));
        end

        // Halt alongside a hit, then drain; redirects afterwards must be ignored.
        step(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, $urandom, 1'b1, 32'h0000_4000, 1'b0, 1'b0);
        repeat (12) begin
            step(1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 3) == 0), $urandom, 1'b0,
                 1'($urandom_range(0, 1)));
        end
        idle_drain();
        step(1'b1, $urandom, 1'b1, 32'h0000_0040, 1'b0, 1'b1);
        step(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
